// File: rtl/csa_accumulator_if.sv
// Handshake bundle between the carry-save dot-product stage, the accumulator
// and the result consumer. Signal names keep the block's port naming.
interface csa_accumulator_if #(
   parameter int IN_WIDTH  = 20,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [IN_WIDTH-1:0]  in_i [2];
   logic                 in_last_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [ACC_WIDTH-1:0] out_o;
   logic [CNT_WIDTH-1:0] out_cnt_o;
   logic                 out_ovf_o;

   modport slave (
      input  in_valid_i, in_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_o, out_cnt_o, out_ovf_o
   );

   modport master (
      output in_valid_i, in_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_o, out_cnt_o, out_ovf_o
   );
endinterface

// File: rtl/csa_accumulator.sv
// Resolves carry-save beats and accumulates them with signed saturation,
// presenting one result (value, beat count, overflow flag) per in_last_i burst.
module csa_accumulator #(
   parameter int IN_WIDTH  = 20,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   csa_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   logic                 in_ready;
   logic                 beat_acc;
   logic [IN_WIDTH-1:0]  beat_sum;
   logic [ACC_WIDTH-1:0] beat_val;
   logic [ACC_WIDTH:0]   acc_wide;
   logic                 pos_ovf;
   logic                 neg_ovf;
   logic [ACC_WIDTH-1:0] acc_sat;

   assign in_ready = (state_q != ST_DONE);
   assign beat_acc = bus.in_valid_i & in_ready;

   // The carry-save pair wraps at IN_WIDTH before sign extension, exactly as
   // the upstream array would have resolved it.
   assign beat_sum = bus.in_i[0] + bus.in_i[1];
   assign beat_val = {{(ACC_WIDTH-IN_WIDTH){beat_sum[IN_WIDTH-1]}}, beat_sum};

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + {beat_val[ACC_WIDTH-1], beat_val};
   assign pos_ovf  = ~acc_wide[ACC_WIDTH] &  acc_wide[ACC_WIDTH-1];
   assign neg_ovf  =  acc_wide[ACC_WIDTH] & ~acc_wide[ACC_WIDTH-1];

   always_comb begin
      acc_sat = acc_wide[ACC_WIDTH-1:0];
      if (pos_ovf) begin
         acc_sat = ACC_MAX;
      end else if (neg_ovf) begin
         acc_sat = ACC_MIN;
      end
   end

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (beat_acc) begin
               acc_d   = beat_val;
               cnt_d   = CNT_ONE;
               ovf_d   = 1'b0;
               state_d = bus.in_last_i ? ST_DONE : ST_ACC;
            end
         end

         ST_ACC: begin
            if (beat_acc) begin
               acc_d   = acc_sat;
               cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
               ovf_d   = ovf_q | pos_ovf | neg_ovf;
               state_d = bus.in_last_i ? ST_DONE : ST_ACC;
            end
         end

         ST_DONE: begin
            // No bypass: the consuming edge only returns to IDLE.
            if (bus.out_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge
         // values regardless of statement order.
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = (state_q == ST_DONE);
   assign bus.out_o       = (state_q == ST_DONE) ? acc_q : '0;
   assign bus.out_cnt_o   = (state_q == ST_DONE) ? cnt_q : '0;
   assign bus.out_ovf_o   = (state_q == ST_DONE) & ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Drives a 32-bit and a 21-bit accumulator with identical stimulus and checks
// both against a bench-side saturating model through a result scoreboard.
module tb_csa_accumulator;

   localparam int IN_W  = 20;
   localparam int CNT_W = 16;
   localparam int W_A   = 32;
   localparam int W_B   = 21;

   typedef enum {M_IDLE, M_ACC, M_DONE} m_state_e;
   typedef struct {
      longint acc;
      int     cnt;
      bit     ovf;
   } res_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_last;
   logic [IN_W-1:0] in_s;
   logic [IN_W-1:0] in_c;
   logic            out_ready;

   int n_checks;
   int n_errors;

   res_t     q_a[$];
   res_t     q_b[$];
   longint   m_acc[2];
   bit       m_ovf[2];
   int       m_cnt;
   m_state_e m_state;

   csa_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(W_A), .CNT_WIDTH(CNT_W)) bus_a ();
   csa_accumulator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(W_B), .CNT_WIDTH(CNT_W)) bus_b ();

   assign bus_a.in_valid_i  = in_valid;
   assign bus_a.in_last_i   = in_last;
   assign bus_a.in_i[0]     = in_s;
   assign bus_a.in_i[1]     = in_c;
   assign bus_a.out_ready_i = out_ready;
   assign bus_b.in_valid_i  = in_valid;
   assign bus_b.in_last_i   = in_last;
   assign bus_b.in_i[0]     = in_s;
   assign bus_b.in_i[1]     = in_c;
   assign bus_b.out_ready_i = out_ready;

   csa_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(W_A), .CNT_WIDTH(CNT_W)) dut_a (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus_a)
   );

   csa_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(W_B), .CNT_WIDTH(CNT_W)) dut_b (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] wrap(input longint v, input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return 64'(v) & m;
   endfunction

   function automatic int width_of(input int i);
      return (i == 0) ? W_A : W_B;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_cnt   = 0;
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_beat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c, input bit last);
      logic [IN_W-1:0] r;
      longint          rv;
      longint          t;
      longint          vmax;
      longint          vmin;
      r  = s + c;
      rv = longint'($signed(r));
      for (int i = 0; i < 2; i++) begin
         vmax = (longint'(1) <<< (width_of(i) - 1)) - 1;
         vmin = -(longint'(1) <<< (width_of(i) - 1));
         if (m_state == M_IDLE) begin
            m_acc[i] = rv;
            m_ovf[i] = 1'b0;
         end else begin
            t = m_acc[i] + rv;
            if (t > vmax) begin
               t = vmax;
               m_ovf[i] = 1'b1;
            end else if (t < vmin) begin
               t = vmin;
               m_ovf[i] = 1'b1;
            end
            m_acc[i] = t;
         end
      end
      if (m_state == M_IDLE) m_cnt = 1;
      else if (m_cnt < 65535) m_cnt++;
      if (last) begin
         m_state = M_DONE;
         q_a.push_back('{m_acc[0], m_cnt, m_ovf[0]});
         q_b.push_back('{m_acc[1], m_cnt, m_ovf[1]});
      end else begin
         m_state = M_ACC;
      end
   endtask

   // Presents one beat at a falling edge; acceptance is predicted by the model.
   task automatic beat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c, input bit last);
      bit acc_ok;
      in_valid = 1'b1;
      in_s     = s;
      in_c     = c;
      in_last  = last;
      acc_ok   = (m_state != M_DONE);
      check("in_ready_a", 64'(bus_a.in_ready_o), 64'(acc_ok));
      check("in_ready_b", 64'(bus_b.in_ready_o), 64'(acc_ok));
      @(posedge clk);
      if (acc_ok) model_beat(s, c, last);
      @(negedge clk);
      if (acc_ok && last) begin
         check("latency_valid_a", 64'(bus_a.out_valid_o), 64'd1);
         check("latency_valid_b", 64'(bus_b.out_valid_o), 64'd1);
      end
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid_a"}, 64'(bus_a.out_valid_o), 64'd0);
      check({tag, "_out_a"},   64'(bus_a.out_o),       64'd0);
      check({tag, "_cnt_a"},   64'(bus_a.out_cnt_o),   64'd0);
      check({tag, "_ovf_a"},   64'(bus_a.out_ovf_o),   64'd0);
      check({tag, "_ready_a"}, 64'(bus_a.in_ready_o),  64'd1);
      check({tag, "_valid_b"}, 64'(bus_b.out_valid_o), 64'd0);
      check({tag, "_out_b"},   64'(bus_b.out_o),       64'd0);
      check({tag, "_cnt_b"},   64'(bus_b.out_cnt_o),   64'd0);
      check({tag, "_ovf_b"},   64'(bus_b.out_ovf_o),   64'd0);
      check({tag, "_ready_b"}, 64'(bus_b.in_ready_o),  64'd1);
   endtask

   task automatic check_front(input string tag);
      res_t ea;
      res_t eb;
      check({tag, "_sb_depth"}, 64'(q_a.size()), 64'd1);
      if (q_a.size() > 0 && q_b.size() > 0) begin
         ea = q_a[0];
         eb = q_b[0];
         check({tag, "_valid_a"}, 64'(bus_a.out_valid_o), 64'd1);
         check({tag, "_out_a"},   64'(bus_a.out_o),       wrap(ea.acc, W_A));
         check({tag, "_cnt_a"},   64'(bus_a.out_cnt_o),   64'(ea.cnt));
         check({tag, "_ovf_a"},   64'(bus_a.out_ovf_o),   64'(ea.ovf));
         check({tag, "_valid_b"}, 64'(bus_b.out_valid_o), 64'd1);
         check({tag, "_out_b"},   64'(bus_b.out_o),       wrap(eb.acc, W_B));
         check({tag, "_cnt_b"},   64'(bus_b.out_cnt_o),   64'(eb.cnt));
         check({tag, "_ovf_b"},   64'(bus_b.out_ovf_o),   64'(eb.ovf));
      end
   endtask

   // Waits (bounded) for a result, compares it, then consumes it.
   task automatic take_result(input string tag);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (!bus_a.out_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_result_seen"}, 64'(bus_a.out_valid_o), 64'd1);
      if (bus_a.out_valid_o) begin
         check_front(tag);
         out_ready = 1'b1;
         @(posedge clk);
         if (q_a.size() > 0) void'(q_a.pop_front());
         if (q_b.size() > 0) void'(q_b.pop_front());
         m_state = M_IDLE;
         @(negedge clk);
         out_ready = 1'b0;
         check_idle({tag, "_after"});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int len;
      logic [IN_W-1:0] rs;
      logic [IN_W-1:0] rc;

      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_s      = '0;
      in_c      = '0;
      out_ready = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // Single beat 5 + 3.
      beat(20'h00005, 20'h00003, 1'b1);
      check("single_out_a", 64'(bus_a.out_o), 64'd8);
      take_result("single");

      // Negative carry-save: -1 + -2.
      beat(20'hFFFFF, 20'hFFFFE, 1'b1);
      check("neg_out_a", 64'(bus_a.out_o), 64'hFFFF_FFFD);
      take_result("neg");

      // Four back-to-back beats of +100.
      for (int i = 0; i < 4; i++) beat(20'd60, 20'd40, i == 3);
      check("b2b_ready_low", 64'(bus_a.in_ready_o), 64'd0);
      check("b2b_out_a", 64'(bus_a.out_o), 64'd400);
      take_result("b2b");

      // Positive saturation on the 21-bit instance.
      for (int i = 0; i < 3; i++) beat(20'h7FFFF, 20'h00000, i == 2);
      check("possat_out_b", 64'(bus_b.out_o), 64'd1048575);
      take_result("possat");

      // Negative saturation on the 21-bit instance.
      for (int i = 0; i < 3; i++) beat(20'h80000, 20'h00000, i == 2);
      check("negsat_out_b", 64'(bus_b.out_o), 64'h10_0000);
      take_result("negsat");

      // Backpressure: beats offered while DONE must be ignored.
      beat(20'd100, 20'd0, 1'b0);
      beat(20'd1, 20'd2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         beat(20'($urandom), 20'($urandom), 1'b1);
         check_front("bp_hold");
      end
      take_result("bp");

      // Reset mid-accumulation discards the partial sum.
      beat(20'd100, 20'd0, 1'b0);
      beat(20'd100, 20'd0, 1'b0);
      idle_cycles(0);
      #2 rst_n = 1'b0;
      #1 check_idle("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat(20'h00007, 20'h00000, 1'b1);
      check("rst_new_out_a", 64'(bus_a.out_o), 64'd7);
      check("rst_new_cnt_a", 64'(bus_a.out_cnt_o), 64'd1);
      take_result("rst_new");

      // Reset while a result is pending.
      beat(20'd9, 20'd9, 1'b1);
      idle_cycles(2);
      #2 rst_n = 1'b0;
      #1 check_idle("done_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("done_reset_rel");

      // Random bursts with idle gaps inside the accumulation.
      for (int t = 0; t < 12; t++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            rs = 20'($urandom);
            rc = 20'($urandom);
            beat(rs, rc, i == len - 1);
            if (i != len - 1) idle_cycles($urandom_range(0, 2));
         end
         take_result("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter IN_WIDTH, default 20, SHALL set the width of each carry-save input word (multiplier-array width sum plus 8).
REQ-002 Parameter ACC_WIDTH, default 32, SHALL set the accumulator and result width; ACC_WIDTH >= IN_WIDTH+1.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the beat-counter width.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  SHALL indicate a valid carry-save pair on in_i.
REQ-007 in_ready_o  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-008 in_i  input  IN_WIDTH x [0:1]  SHALL carry the carry-save pair (sum word, carry word) from the registered dot-product stage.
REQ-009 in_last_i  input  1  SHALL mark the final beat of an accumulation, qualified by in_valid_i.
REQ-010 out_valid_o  output  1  SHALL indicate a final result is presented.
REQ-011 out_ready_i  input  1  SHALL indicate the consumer takes the result.
REQ-012 out_o  output  ACC_WIDTH  SHALL be the signed accumulated result.
REQ-013 out_cnt_o  output  CNT_WIDTH  SHALL be the number of beats accumulated into out_o.
REQ-014 out_ovf_o  output  1  SHALL flag that saturation occurred during the accumulation.

Function
REQ-015 A beat SHALL be accepted on a rising edge where in_valid_i and in_ready_o are both 1.
REQ-016 Resolved value of a beat SHALL be (in_i[0] + in_i[1]) modulo 2^IN_WIDTH, interpreted as two's-complement signed, sign-extended to ACC_WIDTH.
REQ-017 States SHALL be IDLE, ACC, DONE; in_ready_o = 1 in IDLE and ACC, 0 in DONE.
REQ-018 IDLE, accepted beat: acc <= resolved, cnt <= 1, ovf <= 0; go to DONE if in_last_i else ACC.
REQ-019 ACC, accepted beat: acc <= sat(acc + resolved), cnt <= cnt+1 (saturating at all-ones), ovf <= ovf OR saturated; go to DONE if in_last_i else stay.
REQ-020 sat() SHALL clamp to signed ACC_WIDTH bounds: max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1).
REQ-021 IDLE/ACC with no accepted beat SHALL hold all state.
REQ-022 DONE: out_valid_o = 1; out_o, out_cnt_o, out_ovf_o SHALL equal acc, cnt, ovf and remain stable until handshake.
REQ-023 DONE with out_ready_i = 1: result consumed on that edge, next state IDLE; no input beat is accepted in that same cycle (no bypass).
REQ-024 Latency: out_valid_o SHALL rise on the edge that accepts the in_last_i beat (result visible the cycle after the last beat is presented).
REQ-025 Outside DONE, out_valid_o = 0; out_o, out_cnt_o, out_ovf_o SHALL be 0.
REQ-026 in_last_i on the first beat SHALL produce a one-beat result (cnt = 1).

Reset
REQ-027 rst_ni low SHALL immediately force state IDLE, acc/cnt/ovf to 0, out_valid_o 0, out_o 0, out_cnt_o 0, out_ovf_o 0, in_ready_o 1 after release.
REQ-028 Reset during ACC or DONE SHALL discard partial and pending results; the first beat after release starts a new accumulation.

Verification
REQ-029 Single beat: in_i = {0x00005, 0x00003}, last=1 -> next cycle out_valid_o=1, out_o=8, out_cnt_o=1, out_ovf_o=0.
REQ-030 Negative carry-save: in_i = {0xFFFFF, 0xFFFFE}, last=1 -> out_o=0xFFFFFFFD (-3), out_cnt_o=1.
REQ-031 Four back-to-back beats resolving to +100, last on fourth -> out_o=400, out_cnt_o=4, in_ready_o low from the cycle after the 4th beat.
REQ-032 ACC_WIDTH=21: three beats of {0x7FFFF, 0x00000} -> out_o=1048575 (saturated), out_ovf_o=1, out_cnt_o=3.
REQ-033 Backpressure: out_ready_i held 0 for 5 cycles in DONE -> outputs stable, in_ready_o=0, in_valid_i beats not accepted; out_ready_i=1 -> IDLE next cycle, outputs 0.
REQ-034 Reset asserted after 2 of 4 beats -> all outputs 0; new single beat {0x00007, 0x00000}, last=1 -> out_o=7, out_cnt_o=1.
